// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake, status and UART register bus of the transmit scheduler
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic tx_done;
  logic [2:0] tx_done_id;
  logic busy;
  logic timeout_err;
  logic err_clr;
  logic HWRITE;
  logic [64:0] PADDR;
  logic [63:0] PWDATA;
  logic [64:0] PRDATA;
  modport master (
    input req_valid, req_data, err_clr, PRDATA,
    output req_ready, tx_done, tx_done_id, busy, timeout_err, HWRITE, PADDR, PWDATA
  );
  modport slave (
    output req_valid, req_data, err_clr, PRDATA,
    input req_ready, tx_done, tx_done_id, busy, timeout_err, HWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter with clear/send/guard/poll bus sequencing
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter logic [64:0] UART_ADDR = 65'h4001_3800,
  parameter int GUARD_CYCLES = 16,
  parameter int TIMEOUT = 200000
) (
  input logic CLK,
  input logic HRESET,
  uart_tx_scheduler_if.master bus
);
  localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int CW = GW > TW ? GW : TW;
  localparam logic [64:0] SR = UART_ADDR;
  localparam logic [64:0] DR = UART_ADDR + 65'd8;
  typedef enum logic [2:0] {IDLE, CLR, SEND, GUARD, POLL} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] rr_ptr, win;
  logic [3:0] s;
  logic found, take, tc, guard_end, poll_end;
  logic [7:0] vpad, byte_q;
  logic [63:0] dpad;
  logic unused_prdata;
  assign vpad = 8'(bus.req_valid);
  assign dpad = 64'(bus.req_data);
  always_comb begin
    win = '0;
    found = 1'b0;
    s = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, rr_ptr} + 4'(k);
      s = s >= 4'(NREQ) ? s - 4'(NREQ) : s;
      if (!found && vpad[s[2:0]]) begin
        found = 1'b1;
        win = s[2:0];
      end
    end
  end
  assign take = state == IDLE && !HRESET && found;
  assign bus.req_ready = take ? NREQ'(8'b1 << win) : '0;
  assign bus.busy = state != IDLE;
  assign tc = bus.PRDATA[6];
  assign unused_prdata = ^{bus.PRDATA[64:7], bus.PRDATA[5:0]};
  assign guard_end = cnt == '0;
  assign poll_end = cnt == CW'(TIMEOUT - 1);
  always_comb
    nxt = state == IDLE  ? (take ? CLR : IDLE) :
          state == CLR   ? SEND :
          state == SEND  ? GUARD :
          state == GUARD ? (guard_end ? POLL : GUARD) :
          state == POLL && !(tc || poll_end) ? POLL : IDLE;
  always_ff @(posedge CLK)
    state <= HRESET ? IDLE : nxt;
  // bus outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge CLK)
    if (HRESET) begin
      cnt <= '0;
      rr_ptr <= '0;
      byte_q <= '0;
      bus.tx_done_id <= '0;
      bus.tx_done <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.HWRITE <= 1'b0;
      bus.PADDR <= UART_ADDR;
      bus.PWDATA <= '0;
    end else begin
      cnt <= nxt == GUARD ? (state == GUARD ? cnt - CW'(1) : CW'(GUARD_CYCLES - 1)) :
             nxt == POLL && state == POLL ? cnt + CW'(1) : '0;
      rr_ptr <= take ? (win == 3'(NREQ - 1) ? 3'd0 : win + 3'd1) : rr_ptr;
      byte_q <= take ? dpad[{win, 3'b000} +: 8] : byte_q;
      bus.tx_done_id <= take ? win : bus.tx_done_id;
      bus.tx_done <= state == POLL && tc;
      bus.timeout_err <= (state == POLL && !tc && poll_end) || (bus.timeout_err && !bus.err_clr);
      bus.HWRITE <= nxt == CLR || nxt == SEND;
      bus.PADDR <= nxt == SEND ? DR : SR;
      bus.PWDATA <= nxt == SEND ? {56'b0, byte_q} : '0;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter among NREQ byte requesters (cores, debug port, DMA) using round-robin arbitration.
- Acts as the sole bus master toward the UART register block. For each byte it sequences these bus accesses: clear SR, write DR, wait, poll SR.TC.
- Reports completion per byte, and a sticky timeout error if TC never rises.

Parameters:
- NREQ, 4, number of requesters (2..8).
- UART_ADDR, 65'h4001_3800, UART register base; SR at +0, DR at +8.
- GUARD_CYCLES, 16, CLK cycles to wait after the DR write before polling starts; covers div_clk latency of the TXE/TC flags.
- TIMEOUT, 200000, maximum POLL cycles per byte before the byte is abandoned.

Ports:
- CLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte pending.
- req_data  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot; byte i accepted in the cycle where req_valid[i] and req_ready[i] are both high.
- tx_done  out  1  one-cycle pulse when a byte's TC is observed.
- tx_done_id  out  3  requester index for tx_done / timeout_err; held until the next grant.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on timeout.
- err_clr  in  1  clears timeout_err.
- HWRITE  out  1  UART bus write strobe.
- PADDR  out  65  UART bus address.
- PWDATA  out  64  UART bus write data.
- PRDATA  in  65  UART bus read data, combinational from PADDR.

Behaviour:
- Reset (sync, HRESET=1 at posedge):
  - state=IDLE; rr_ptr=0.
  - req_ready=0, tx_done=0, tx_done_id=0, busy=0, timeout_err=0.
  - HWRITE=0, PADDR=UART_ADDR, PWDATA=0.
  - Reset mid-operation abandons the current byte silently; no tx_done pulse. The UART may still shift the byte out.
- States: IDLE -> CLR -> SEND -> GUARD -> POLL -> IDLE. All bus outputs are registered, and no combinational path exists from req_* to HWRITE/PADDR/PWDATA.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On handshake: latch the byte, set tx_done_id=winner, set rr_ptr=(winner+1) mod NREQ, go to CLR.
  - No request pending: stay in IDLE with HWRITE=0 and PADDR=UART_ADDR.
- CLR (1 cycle): HWRITE=1, PADDR=UART_ADDR+0, PWDATA=0. Clears stale TXE(bit7) and TC(bit6).
- SEND (1 cycle): HWRITE=1, PADDR=UART_ADDR+8, PWDATA={56'b0,byte}. This write starts the UART transmission.
- GUARD:
  - HWRITE=0, PADDR=UART_ADDR+0.
  - Counter loads GUARD_CYCLES-1 on entry; exit to POLL when it reaches 0.
  - TC is ignored during GUARD.
- POLL:
  - HWRITE=0, PADDR=UART_ADDR+0, PRDATA sampled each cycle.
  - PRDATA[6]==1: tx_done=1 for one cycle, go to IDLE.
  - Timeout counter reaches TIMEOUT-1 with TC still 0: timeout_err=1, go to IDLE, no tx_done.
  - TC and timeout in the same cycle: TC wins.
  - PRDATA bits above 6, and z values on unrelated addresses, are ignored.
- Minimum per-byte occupancy: 1 (IDLE accept) + 1 + 1 + GUARD_CYCLES + 1 cycles.
- req_valid deasserting while the scheduler is busy has no effect. A request is only sampled in IDLE.
- err_clr vs. timeout_err:
  - err_clr=1 clears timeout_err at the next edge.
  - A timeout in the same cycle as err_clr sets timeout_err (set wins).
- Counter widths: sized by $clog2 of the respective parameter; no wrap is possible before exit.
- rr_ptr wraps NREQ-1 -> 0.

Test Plan:
- Reset behaviour: HRESET=1 for 2 cycles with req_valid=4'b1111 -> all outputs at reset values, req_ready=0; first grant after release goes to requester 0.
- Single byte: req_valid[2]=1, data 8'hA5; UART model raises TC 40 cycles after the DR write -> exact bus sequence:
  - one cycle SR write 0,
  - one cycle DR write 64'hA5,
  - 16 cycles of SR reads, then SR reads until TC,
  - tx_done=1 with tx_done_id=2, then IDLE.
- Round-robin: all 4 requesters hold valid for 8 bytes -> grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row while others are waiting.
- Timeout: model never sets TC, TIMEOUT=100 -> timeout_err=1 after 100 POLL cycles, no tx_done; next request is still served; err_clr pulse returns timeout_err to 0.
- Stale TC: model holds TC=1 during GUARD and clears it on the CLR write, then raises it late -> tx_done fires only on the late TC.
- Mid-operation reset: HRESET asserted during POLL -> next cycle state=IDLE, HWRITE=0, busy=0, no tx_done pulse.
